// File: rtl/param_fifo.sv
// Synchronous single-clock FIFO with registered read port, occupancy counter,
// almost-full/empty thresholds, empty-bypass and sticky overflow/underflow flags.
module param_fifo #(
  parameter int DataWidth        = 8,
  parameter int Depth            = 8,
  parameter int AlmostFullLevel  = Depth - 2,
  parameter int AlmostEmptyLevel = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [DataWidth-1:0]   cData,
  input  logic                   cPush,
  input  logic                   cPop,
  input  logic                   cFlush,
  input  logic                   cClearErr,
  output logic [DataWidth-1:0]   hData,
  output logic                   hFull,
  output logic                   hEmpty,
  output logic                   hAlmostFull,
  output logic                   hAlmostEmpty,
  output logic [$clog2(Depth):0] hCount,
  output logic                   hOverflow,
  output logic                   hUnderflow
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;
  localparam logic [CntW-1:0] DepthCnt = CntW'(Depth);
  localparam logic [CntW-1:0] AfLevel  = CntW'(AlmostFullLevel);
  localparam logic [CntW-1:0] AeLevel  = CntW'(AlmostEmptyLevel);

  logic [DataWidth-1:0] mem_q [Depth];

  logic [PtrW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]      count_q,  count_d;
  logic [DataWidth-1:0] data_q,   data_d;
  logic                 ovf_q,    ovf_d;
  logic                 udf_q,    udf_d;

  logic full, empty, bypass, do_push, do_pop, ovf_evt, udf_evt, mem_we;

  always_comb begin
    full     = (count_q == DepthCnt);
    empty    = (count_q == '0);
    // Push+pop on an empty FIFO forwards the word straight to hData.
    bypass   = cPush && cPop && empty;
    do_pop   = cPop && !empty;
    do_push  = cPush && !bypass && (!full || cPop);
    ovf_evt  = cPush && !cPop && full && !cFlush;
    udf_evt  = cPop && !cPush && empty && !cFlush;
    mem_we   = do_push && !cFlush;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    data_d   = data_q;

    if (cFlush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
        data_d   = mem_q[rd_ptr_q];
      end
      if (bypass) begin
        data_d = cData;
      end
      if (do_push && !do_pop) begin
        count_d = count_q + CntW'(1);
      end else if (do_pop && !do_push) begin
        count_d = count_q - CntW'(1);
      end
    end

    // A coinciding error event wins over the clear request.
    ovf_d = (ovf_q && !cClearErr) || ovf_evt;
    udf_d = (udf_q && !cClearErr) || udf_evt;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  // Storage is not reset; stale words are unreachable once the pointers clear.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= cData;
    end
  end

  assign hData        = data_q;
  assign hCount       = count_q;
  assign hFull        = full;
  assign hEmpty       = empty;
  assign hAlmostFull  = (count_q >= AfLevel);
  assign hAlmostEmpty = (count_q <= AeLevel);
  assign hOverflow    = ovf_q;
  assign hUnderflow   = udf_q;

endmodule

// File: tb/tb_param_fifo.sv
// Bench for param_fifo: queue-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_param_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 8;
  localparam int AFL   = 6;
  localparam int AEL   = 2;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [DW-1:0] cData = '0;
  logic          cPush = 1'b0;
  logic          cPop = 1'b0;
  logic          cFlush = 1'b0;
  logic          cClearErr = 1'b0;
  logic [DW-1:0] hData;
  logic          hFull, hEmpty, hAlmostFull, hAlmostEmpty;
  logic [3:0]    hCount;
  logic          hOverflow, hUnderflow;

  param_fifo #(
    .DataWidth(DW), .Depth(DEPTH), .AlmostFullLevel(AFL), .AlmostEmptyLevel(AEL)
  ) dut (
    .clock(clock), .reset(reset), .cData(cData), .cPush(cPush), .cPop(cPop),
    .cFlush(cFlush), .cClearErr(cClearErr), .hData(hData), .hFull(hFull),
    .hEmpty(hEmpty), .hAlmostFull(hAlmostFull), .hAlmostEmpty(hAlmostEmpty),
    .hCount(hCount), .hOverflow(hOverflow), .hUnderflow(hUnderflow)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_err = 0;

  logic [DW-1:0] mq [$];
  logic [DW-1:0] m_data = '0;
  bit            m_ovf = 1'b0;
  bit            m_udf = 1'b0;
  bit            chk_en = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: what one rising edge does to the FIFO contents.
  task automatic model_step(input bit push, input bit pop, input bit flush,
                            input bit clr, input logic [DW-1:0] din);
    int sz;
    bit was_empty, was_full, ovf_ev, udf_ev;
    sz        = mq.size();
    was_empty = (sz == 0);
    was_full  = (sz == DEPTH);
    ovf_ev    = 1'b0;
    udf_ev    = 1'b0;
    if (flush) begin
      mq.delete();
    end else if (push && pop && was_empty) begin
      m_data = din;
    end else begin
      if (pop && !was_empty) m_data = mq.pop_front();
      if (push && (!was_full || pop)) mq.push_back(din);
      ovf_ev = push && !pop && was_full;
      udf_ev = pop && !push && was_empty;
    end
    m_ovf = (m_ovf && !clr) || ovf_ev;
    m_udf = (m_udf && !clr) || udf_ev;
  endtask

  task automatic step(input bit push, input bit pop, input bit flush,
                      input bit clr, input logic [DW-1:0] din);
    cPush = push; cPop = pop; cFlush = flush; cClearErr = clr; cData = din;
    @(posedge clock);
    model_step(push, pop, flush, clr, din);
    @(negedge clock);
  endtask

  task automatic model_reset();
    mq.delete();
    m_data = '0;
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      chk("count",        int'(hCount),       mq.size());
      chk("full",         int'(hFull),        int'(mq.size() == DEPTH));
      chk("empty",        int'(hEmpty),       int'(mq.size() == 0));
      chk("almost_full",  int'(hAlmostFull),  int'(mq.size() >= AFL));
      chk("almost_empty", int'(hAlmostEmpty), int'(mq.size() <= AEL));
      chk("data",         int'(hData),        int'(m_data));
      chk("overflow",     int'(hOverflow),    int'(m_ovf));
      chk("underflow",    int'(hUnderflow),   int'(m_udf));
    end
  end

  initial begin
    #3;
    chk("rst_count", int'(hCount), 0);
    chk("rst_empty", int'(hEmpty), 1);
    chk("rst_full",  int'(hFull), 0);
    chk("rst_ae",    int'(hAlmostEmpty), 1);
    chk("rst_af",    int'(hAlmostFull), 0);
    chk("rst_data",  int'(hData), 0);
    chk("rst_ovf",   int'(hOverflow), 0);
    chk("rst_udf",   int'(hUnderflow), 0);
    chk_en = 1'b1;
    @(negedge clock);
    reset = 1'b1;

    // Fill 1..8, then drain in order.
    for (int i = 1; i <= 8; i++) begin
      step(1, 0, 0, 0, 8'(i));
      chk("af_after_push", int'(hAlmostFull), int'(i >= 6));
    end
    chk("fill_count", int'(hCount), 8);
    chk("fill_full",  int'(hFull), 1);
    for (int i = 1; i <= 8; i++) begin
      step(0, 1, 0, 0, 8'h00);
      chk("pop_order", int'(hData), i);
    end
    chk("drain_empty", int'(hEmpty), 1);

    // Overflow while full.
    for (int i = 1; i <= 8; i++) step(1, 0, 0, 0, 8'(i));
    step(1, 0, 0, 0, 8'hAA);
    chk("ovf_set",   int'(hOverflow), 1);
    chk("ovf_count", int'(hCount), 8);
    for (int i = 1; i <= 8; i++) begin
      step(0, 1, 0, 0, 8'h00);
      chk("ovf_pop_order", int'(hData), i);
    end
    step(0, 0, 0, 1, 8'h00);
    chk("ovf_clear", int'(hOverflow), 0);

    // Bypass on empty, then underflow.
    step(1, 1, 0, 0, 8'h5C);
    chk("byp_data",  int'(hData), 8'h5C);
    chk("byp_count", int'(hCount), 0);
    chk("byp_udf",   int'(hUnderflow), 0);
    step(0, 1, 0, 0, 8'h00);
    chk("udf_set",  int'(hUnderflow), 1);
    chk("udf_hold", int'(hData), 8'h5C);
    step(1, 0, 0, 1, 8'h11);
    chk("udf_clear", int'(hUnderflow), 0);
    step(0, 1, 0, 0, 8'h00);
    chk("after_clr_pop", int'(hData), 8'h11);

    // Twenty pushes with interleaved pops so the pointers wrap twice.
    for (int i = 0; i < 20; i++) step(1, (i % 3) != 0, 0, 0, 8'(8'h20 + i));
    while (mq.size() != 0) step(0, 1, 0, 0, 8'h00);

    // Flush beats a coincident push.
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 8'(8'h40 + i));
    chk("pre_flush_count", int'(hCount), 5);
    step(1, 0, 1, 0, 8'h77);
    chk("flush_count", int'(hCount), 0);
    chk("flush_empty", int'(hEmpty), 1);
    chk("flush_ovf",   int'(hOverflow), 0);
    chk("flush_udf",   int'(hUnderflow), 0);

    // Mid-stream asynchronous reset with a sticky error pending.
    for (int i = 0; i < 9; i++) step(1, 0, 0, 0, 8'(8'h60 + i));
    step(0, 1, 0, 0, 8'h00);
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    chk("arst_count", int'(hCount), 0);
    chk("arst_empty", int'(hEmpty), 1);
    chk("arst_full",  int'(hFull), 0);
    chk("arst_af",    int'(hAlmostFull), 0);
    chk("arst_ae",    int'(hAlmostEmpty), 1);
    chk("arst_data",  int'(hData), 0);
    chk("arst_ovf",   int'(hOverflow), 0);
    @(posedge clock);
    #2;
    reset = 1'b1;
    @(negedge clock);
    step(1, 0, 0, 0, 8'h3D);
    chk("first_push_count", int'(hCount), 1);
    step(0, 1, 0, 0, 8'h00);
    chk("first_push_data", int'(hData), 8'h3D);

    // Randomized traffic: push-heavy, then pop-heavy, then balanced.
    for (int i = 0; i < 600; i++) begin
      int pp, pq;
      pp = (i < 200) ? 70 : (i < 400) ? 30 : 50;
      pq = 100 - pp;
      step($urandom_range(0, 99) < pp, $urandom_range(0, 99) < pq,
           $urandom_range(0, 99) < 2, $urandom_range(0, 99) < 6,
           8'($urandom));
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
